iu_issue_arbiter: RTL

Round-robin issue arbiter that shares one integer unit between `NumRequesters` operand-collector ports. It selects one valid requester per cycle and forwards its tag, subtype, destination and operands to the execution unit. It holds the grant stable while the unit back-pressures. It bounds the number of instructions in flight between issue and result-collector acceptance with a credit counter. The block sits between the operand collectors and the integer unit inside the compute unit.

---
 rtl/iu_issue_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/iu_issue_arbiter.sv
// Round-robin issue arbiter sharing one integer unit between operand-collector ports,
// with grant locking under back-pressure and a credit limit on in-flight instructions.
module iu_issue_arbiter #(
  parameter int unsigned NumRequesters   = 4,
  parameter int unsigned RegWidth        = 32,
  parameter int unsigned WarpWidth       = 4,
  parameter int unsigned OperandsPerInst = 2,
  parameter int unsigned MaxInFlight     = 2,
  parameter type iid_t       = logic,
  parameter type reg_idx_t   = logic,
  parameter type inst_sub_t  = logic [3:0],
  parameter type warp_data_t = logic [RegWidth*WarpWidth-1:0],
  localparam int unsigned IdxWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1,
  localparam int unsigned CntWidth = $clog2(MaxInFlight + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumRequesters-1:0] opc_valid_i,
  output logic [NumRequesters-1:0] opc_ready_o,
  input  iid_t                     opc_tag_i      [NumRequesters],
  input  inst_sub_t                opc_inst_sub_i [NumRequesters],
  input  reg_idx_t                 opc_dst_i      [NumRequesters],
  input  warp_data_t               opc_operands_i [NumRequesters][OperandsPerInst],
  output logic                     eu_valid_o,
  input  logic                     eu_ready_i,
  output iid_t                     eu_tag_o,
  output inst_sub_t                eu_inst_sub_o,
  output reg_idx_t                 eu_dst_o,
  output warp_data_t               eu_operands_o  [OperandsPerInst],
  input  logic                     eu_done_i,
  output logic [IdxWidth-1:0]      grant_idx_o,
  output logic [CntWidth-1:0]      inflight_o
);

  logic [IdxWidth-1:0] rr_r;
  logic [IdxWidth-1:0] lock_idx_r;
  logic                lock_r;
  logic [CntWidth-1:0] inflight_r;

  logic [IdxWidth-1:0] cand_s;
  logic [IdxWidth-1:0] scan_sel_s;
  logic [IdxWidth-1:0] sel_s;
  logic [IdxWidth-1:0] rr_next_s;
  logic                found_s;
  logic                hit_s;
  logic                can_issue_s;
  logic                issue_s;
  logic                stall_s;

  // Reset gates the credit so nothing is offered to the unit while rst_i is held.
  assign can_issue_s = ~rst_i & (inflight_r < CntWidth'(MaxInFlight));

  // Round-robin scan: first valid requester at or above the pointer, wrapping.
  always_comb begin
    scan_sel_s = rr_r;
    found_s    = 1'b0;
    cand_s     = rr_r;
    hit_s      = 1'b0;
    for (int i = 0; i < int'(NumRequesters); i++) begin
      cand_s     = IdxWidth'((int'(rr_r) + i) % int'(NumRequesters));
      hit_s      = ~found_s & opc_valid_i[cand_s];
      scan_sel_s = hit_s ? cand_s : scan_sel_s;
      found_s    = found_s | hit_s;
    end
  end

  assign sel_s     = lock_r ? lock_idx_r : scan_sel_s;
  assign rr_next_s = (sel_s == IdxWidth'(NumRequesters - 1)) ? {IdxWidth{1'b0}}
                                                            : sel_s + IdxWidth'(1);

  assign eu_valid_o = can_issue_s & opc_valid_i[sel_s];
  assign issue_s    = eu_valid_o & eu_ready_i;
  assign stall_s    = eu_valid_o & ~eu_ready_i;

  // Only the selected port sees the unit's ready.
  always_comb begin
    opc_ready_o        = {NumRequesters{1'b0}};
    opc_ready_o[sel_s] = can_issue_s & eu_ready_i;
  end

  // Payload mux from the selected requester.
  always_comb begin
    eu_tag_o      = opc_tag_i[sel_s];
    eu_inst_sub_o = opc_inst_sub_i[sel_s];
    eu_dst_o      = opc_dst_i[sel_s];
    for (int k = 0; k < int'(OperandsPerInst); k++) begin
      eu_operands_o[k] = opc_operands_i[sel_s][k];
    end
  end

  assign grant_idx_o = sel_s;
  assign inflight_o  = inflight_r;

  // Pointer, lock and credit state. The lock is simply "offered but not taken last cycle",
  // so a locked requester that drops valid releases the lock on the next edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_r       <= {IdxWidth{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IdxWidth{1'b0}};
      inflight_r <= {CntWidth{1'b0}};
    end else begin
      rr_r       <= issue_s ? rr_next_s : rr_r;
      lock_r     <= stall_s;
      lock_idx_r <= stall_s ? sel_s : lock_idx_r;
      case ({issue_s, eu_done_i})
        2'b10:   inflight_r <= inflight_r + CntWidth'(1);
        2'b01:   inflight_r <= (inflight_r == {CntWidth{1'b0}}) ? inflight_r
                                                               : inflight_r - CntWidth'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  iu_issue_arbiter_chk #(
    .CntWidth    (CntWidth),
    .MaxInFlight (MaxInFlight)
  ) u_chk (
    .clk        (clk_i),
    .rst        (rst_i),
    .done       (eu_done_i),
    .issue      (issue_s),
    .lock       (lock_r),
    .lock_valid (opc_valid_i[lock_idx_r]),
    .inflight   (inflight_r)
  );

endmodule

// Protocol checks on the arbiter's credit counter and locked-requester behaviour.
module iu_issue_arbiter_chk #(
  parameter int unsigned CntWidth    = 2,
  parameter int unsigned MaxInFlight = 2
) (
  input logic                clk,
  input logic                rst,
  input logic                done,
  input logic                issue,
  input logic                lock,
  input logic                lock_valid,
  input logic [CntWidth-1:0] inflight
);

  a_done_when_empty: assert property (@(posedge clk) disable iff (rst)
    done |-> (inflight != {CntWidth{1'b0}}))
    else $error("eu_done_i with no instruction in flight");

  a_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    issue |-> (inflight != CntWidth'(MaxInFlight)))
    else $error("issue with no credit left");

  a_locked_valid_held: assert property (@(posedge clk) disable iff (rst)
    lock |-> lock_valid)
    else $error("locked requester dropped valid");

endmodule
